multi_client: RTL and testbench
===============================

Name: multi_client

Overview:
- Parametrised successor to the single-stream AXI-Stream client.
- Accepts NUM_CH independent producer streams. Each stream has its own FIFO, and each FIFO entry stores tlast with the data, so tlast alignment is exact per beat.
- A packet-locked round-robin arbiter merges the streams onto one NoC AXI-Stream master interface.
- Each channel has its own destination address. tid carries the source channel index.

Parameters:
- DATAW, 64, payload width per beat.
- DEPTH, 16, entries per channel FIFO; power of two, at least 2.
- NUM_CH, 4, number of input channels; 1..16.
- CHW, $clog2(NUM_CH) (minimum 1), channel index width; derived.
- AXIS_DATAW, 512, output tdata width; at least DATAW.
- DESTW, 12, tdest width.
- USERW, 12, tuser width.
- IDW, 8, tid width; at least CHW.
- DEST_ADDRS, 0, packed NUM_CH*DESTW vector; slice i is the destination for channel i.
- SRC_ADDR, 0, constant driven on tuser.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- client_tdata  in  NUM_CH*DATAW  per-channel data; slice i belongs to channel i
- client_tlast  in  NUM_CH  per-channel end-of-packet flag, qualified by valid
- client_valid  in  NUM_CH  per-channel write request
- client_ready  out  NUM_CH  per-channel space available
- axis_tready  in  1  NoC interface ready
- axis_tvalid  out  1  output beat valid
- axis_tlast  out  1  last beat of packet
- axis_tdata  out  AXIS_DATAW  zero-extended payload
- axis_tdest  out  DESTW  DEST_ADDRS slice of the granted channel
- axis_tid  out  IDW  granted channel index, zero-extended
- axis_tuser  out  USERW  SRC_ADDR
- axis_tstrb  out  AXIS_DATAW/8  constant all-zero
- axis_tkeep  out  AXIS_DATAW/8  constant all-zero
- beats_sent  out  32  count of output handshakes; wraps
- pkts_sent  out  32  count of output handshakes with tlast; wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - all FIFOs empty, arbiter in IDLE, rr_ptr=0, grant=0, counters 0.
  - Outputs: axis_tvalid=0, client_ready all 1, axis_tlast=0.
  - Reset mid-packet discards all buffered and in-flight beats; no partial packet resumes.
- Write side, channel i:
  - client_ready[i] = ~full[i], where full is registered.
  - Write when valid[i] & ready[i]; the entry is {tlast[i], tdata[i]}.
  - valid while full is ignored; the producer holds the beat.
- FIFO:
  - Show-ahead: the head entry is visible the cycle after the first write.
  - Simultaneous read and write keeps occupancy unchanged and is legal at any level, including DEPTH-1.
  - Pointers wrap mod DEPTH; full/empty use an extra wrap bit.
- Arbiter FSM, two states:
  - IDLE: if any FIFO is non-empty, select the first non-empty channel scanning rr_ptr, rr_ptr+1, ... mod NUM_CH. Register grant, go to LOCKED. No output this cycle.
  - LOCKED:
    - axis_tvalid = ~empty[grant].
    - Other outputs are taken from the head of FIFO[grant]: payload, tlast, dest slice, tid.
    - Read FIFO[grant] on tvalid & tready.
    - If the handshaken beat has tlast=1: rr_ptr <= (grant+1) mod NUM_CH, return to IDLE.
    - An empty granted FIFO mid-packet keeps the lock (tvalid=0, bubble); other channels wait.
- Latency: beat written at cycle t is at the FIFO head at t+1, granted at t+2, and axis_tvalid is high at t+2 at the earliest.
- Throughput: one beat per cycle within a packet; one idle cycle between packets.
- AXIS rule: while tvalid=1 and tready=0, all output fields stay stable.
- Counters: beats_sent increments on every handshake; pkts_sent also increments when tlast=1. Both wrap 0xFFFFFFFF to 0.
- A packet whose tlast never arrives holds the lock indefinitely; this is by design.

Decomposition:
- Shared package/header (`static_params.vh`): default DATAW, DEPTH, NUM_CH, AXIS widths, SRC_ADDR, default DEST_ADDRS, FSM state encodings (IDLE=0, LOCKED=1).
- Sub-module client_fifo: show-ahead synchronous FIFO, parametrised DATA_WIDTH/DEPTH, async active-low reset, ports w_enable, r_enable, data_in, data_out, full, empty.
- Instantiate client_fifo NUM_CH times in a generate loop. Arbiter and counters stay in multi_client.

Test Plan:
- Single channel, 3-beat packet: NUM_CH=4, ch0 writes 10, 20, 30 (tlast on 30) from cycle 0, tready=1.
  - Outputs 10/20/30 at cycles 2, 3, 4; tlast only with 30; tdest=DEST_ADDRS[0]; tid=0; pkts_sent=1; beats_sent=3.
- Round-robin fairness: ch1 and ch3 each hold two 2-beat packets, rr_ptr=0.
  - Packet order is ch1, ch3, ch1, ch3; no beat interleaving within a packet.
- Backpressure: tready=0 for 5 cycles mid-packet.
  - tvalid, tdata, tlast, tdest stay stable; no beat lost or duplicated; counters frozen.
- Full FIFO: DEPTH=4, tready=0, ch2 writes 6 beats.
  - client_ready[2]=0 after the 4th write; beats 5–6 are held by the producer; all 6 beats later arrive in order.
- Mid-packet starvation: ch0 sends 1 beat without tlast, then ch1 sends a full packet.
  - The ch1 packet waits; tvalid=0 bubbles; ch0 completes with tlast; ch1 then follows.
- Async reset: assert rst=0 mid-packet between clock edges.
  - Immediately tvalid=0, client_ready all 1, counters 0; after release, a fresh ch0 packet is output with normal latency.

Source files
------------

// File: rtl/multi_client_pkg.sv
// Shared defaults, FSM state type and helpers for the multi-channel AXI-Stream client.
package multi_client_pkg;

  localparam int DEF_DATAW      = 64;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_AXIS_DATAW = 512;
  localparam int DEF_DESTW      = 12;
  localparam int DEF_USERW      = 12;
  localparam int DEF_IDW        = 8;
  localparam logic [DEF_USERW-1:0] DEF_SRC_ADDR = '0;

  // Arbiter states: IDLE picks the next channel, LOCKED streams one packet.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/client_fifo.sv
// Show-ahead synchronous FIFO: the head entry is on data_out whenever empty=0.
module client_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_enable,
  input  logic                  r_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  do_wr;
  logic                  do_rd;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_wr    = w_enable & ~full;
  assign do_rd    = r_enable & ~empty;
  assign data_out = mem[rd_ptr_reg[AW-1:0]];

  // Storage array; contents need no reset because empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= data_in;
  end

  // Pointer update; concurrent read and write leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/multi_client.sv
// Merges NUM_CH buffered producer streams onto one AXI-Stream master with a
// packet-locked round-robin arbiter; tid carries the source channel.
module multi_client
  import multi_client_pkg::*;
#(
  parameter int DATAW      = DEF_DATAW,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AXIS_DATAW = DEF_AXIS_DATAW,
  parameter int DESTW      = DEF_DESTW,
  parameter int USERW      = DEF_USERW,
  parameter int IDW        = DEF_IDW,
  parameter logic [NUM_CH*DESTW-1:0] DEST_ADDRS = '0,
  parameter logic [USERW-1:0]        SRC_ADDR   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*DATAW-1:0]   client_tdata,
  input  logic [NUM_CH-1:0]         client_tlast,
  input  logic [NUM_CH-1:0]         client_valid,
  output logic [NUM_CH-1:0]         client_ready,
  input  logic                      axis_tready,
  output logic                      axis_tvalid,
  output logic                      axis_tlast,
  output logic [AXIS_DATAW-1:0]     axis_tdata,
  output logic [DESTW-1:0]          axis_tdest,
  output logic [IDW-1:0]            axis_tid,
  output logic [USERW-1:0]          axis_tuser,
  output logic [AXIS_DATAW/8-1:0]   axis_tstrb,
  output logic [AXIS_DATAW/8-1:0]   axis_tkeep,
  output logic [31:0]               beats_sent,
  output logic [31:0]               pkts_sent
);

  localparam int CHW = chan_width(NUM_CH);
  localparam int EW  = DATAW + 1;

  arb_state_t        state_reg;
  logic [CHW-1:0]    grant_reg;
  logic [CHW-1:0]    rr_ptr_reg;
  logic [31:0]       beats_sent_reg;
  logic [31:0]       pkts_sent_reg;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  logic [EW-1:0]     head [NUM_CH];
  logic [EW-1:0]     head_sel;
  logic              handshake;
  logic              any_pending;
  logic [CHW-1:0]    pick;
  logic [CHW-1:0]    scan_idx;
  logic [CHW-1:0]    grant_succ;

  // One FIFO per channel; each entry is {tlast, tdata}.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_en[gi] = client_valid[gi] & ~full[gi];
      assign rd_en[gi] = handshake & (grant_reg == CHW'(gi));

      client_fifo #(
        .DATA_WIDTH (EW),
        .DEPTH      (DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .w_enable (wr_en[gi]),
        .r_enable (rd_en[gi]),
        .data_in  ({client_tlast[gi], client_tdata[gi*DATAW +: DATAW]}),
        .data_out (head[gi]),
        .full     (full[gi]),
        .empty    (empty[gi])
      );
    end
  endgenerate

  assign client_ready = ~full;
  assign any_pending  = |(~empty);
  assign head_sel     = head[grant_reg];
  assign grant_succ   = (grant_reg == CHW'(NUM_CH - 1)) ? '0 : CHW'(grant_reg + 1'b1);

  // Output fields come straight from the granted FIFO head, so they hold
  // steady under backpressure; tlast is masked during bubbles.
  assign axis_tvalid = (state_reg == ST_LOCKED) & ~empty[grant_reg];
  assign handshake   = axis_tvalid & axis_tready;
  assign axis_tlast  = axis_tvalid & head_sel[DATAW];
  assign axis_tdata  = AXIS_DATAW'(head_sel[DATAW-1:0]);
  assign axis_tdest  = DEST_ADDRS[int'(grant_reg)*DESTW +: DESTW];
  assign axis_tid    = IDW'(grant_reg);
  assign axis_tuser  = SRC_ADDR;
  assign axis_tstrb  = '0;
  assign axis_tkeep  = '0;
  assign beats_sent  = beats_sent_reg;
  assign pkts_sent   = pkts_sent_reg;

  // First non-empty channel scanning upward from rr_ptr, wrapping at NUM_CH.
  always_comb begin
    pick     = rr_ptr_reg;
    scan_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      scan_idx = CHW'((int'(rr_ptr_reg) + k) % NUM_CH);
      if (!empty[scan_idx]) pick = scan_idx;
    end
  end

  // Arbiter: lock onto one channel until its tlast beat is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_pending) begin
            grant_reg <= pick;
            state_reg <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (handshake && head_sel[DATAW]) begin
            rr_ptr_reg <= grant_succ;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Handshake counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_sent_reg <= '0;
      pkts_sent_reg  <= '0;
    end else if (handshake) begin
      beats_sent_reg <= beats_sent_reg + 32'd1;
      if (axis_tlast) pkts_sent_reg <= pkts_sent_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_multi_client.sv
// Randomised and directed bench for multi_client with a queue-based reference model.
module tb_multi_client;

  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int DEP   = 4;
  localparam int ADW   = 64;
  localparam int DESTW = 12;
  localparam int USERW = 12;
  localparam int IDW   = 8;
  localparam logic [NCH*DESTW-1:0] DESTS = {12'h333, 12'h222, 12'h111, 12'h0A0};
  localparam logic [USERW-1:0]     SRC   = 12'h5A5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NCH*DW-1:0]   client_tdata = '0;
  logic [NCH-1:0]      client_tlast = '0;
  logic [NCH-1:0]      client_valid = '0;
  logic [NCH-1:0]      client_ready;
  logic                axis_tready = 1'b0;
  logic                axis_tvalid;
  logic                axis_tlast;
  logic [ADW-1:0]      axis_tdata;
  logic [DESTW-1:0]    axis_tdest;
  logic [IDW-1:0]      axis_tid;
  logic [USERW-1:0]    axis_tuser;
  logic [ADW/8-1:0]    axis_tstrb;
  logic [ADW/8-1:0]    axis_tkeep;
  logic [31:0]         beats_sent;
  logic [31:0]         pkts_sent;

  multi_client #(
    .DATAW(DW), .DEPTH(DEP), .NUM_CH(NCH), .AXIS_DATAW(ADW), .DESTW(DESTW),
    .USERW(USERW), .IDW(IDW), .DEST_ADDRS(DESTS), .SRC_ADDR(SRC)
  ) dut (
    .clk(clk), .rst(rst),
    .client_tdata(client_tdata), .client_tlast(client_tlast),
    .client_valid(client_valid), .client_ready(client_ready),
    .axis_tready(axis_tready), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
    .axis_tdata(axis_tdata), .axis_tdest(axis_tdest), .axis_tid(axis_tid),
    .axis_tuser(axis_tuser), .axis_tstrb(axis_tstrb), .axis_tkeep(axis_tkeep),
    .beats_sent(beats_sent), .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
  typedef struct { int cyc; int ch; logic last; logic [DW-1:0] data; logic [DESTW-1:0] dest; } obs_t;

  beat_t       src_q [NCH][$];   // producer beats not yet accepted
  beat_t       mq    [NCH][$];   // model: beats buffered inside the DUT
  obs_t        out_log[$];
  int          wr_cnt [NCH];
  int          first_wr_cyc = -1;
  bit          m_locked;
  int          m_grant, m_rr;
  logic [31:0] m_beats, m_pkts;
  int          vld_pct = 100;
  int          rdy_pct = 100;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  bit             exp_valid;
  beat_t          h;
  logic [NCH-1:0] rdy_now;
  int             idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle model: check outputs, drive producers/tready, then advance the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_locked = 0; m_grant = 0; m_rr = 0; m_beats = 0; m_pkts = 0;
      client_valid = '0;
      axis_tready  = 1'b0;
    end else begin
      cyc++;
      exp_valid = m_locked && (mq[m_grant].size() != 0);
      for (int c = 0; c < NCH; c++) rdy_now[c] = (mq[c].size() < DEP);
      check("tvalid", axis_tvalid, exp_valid);
      check("client_ready", client_ready, rdy_now);
      check("beats_sent", beats_sent, m_beats);
      check("pkts_sent", pkts_sent, m_pkts);
      check("tuser", axis_tuser, SRC);
      check("tstrb_tkeep", {axis_tstrb, axis_tkeep}, '0);
      if (exp_valid) begin
        h = mq[m_grant][0];
        check("tdata", axis_tdata, 64'(h.data));
        check("tlast", axis_tlast, h.last);
        check("tdest", axis_tdest, DESTS[m_grant*DESTW +: DESTW]);
        check("tid", axis_tid, m_grant);
      end
      axis_tready = ($urandom_range(99) < rdy_pct);
      for (int c = 0; c < NCH; c++) begin
        if (src_q[c].size() != 0 && $urandom_range(99) < vld_pct) begin
          client_valid[c] = 1'b1;
          client_tdata[c*DW +: DW] = src_q[c][0].data;
          client_tlast[c] = src_q[c][0].last;
        end else begin
          client_valid[c] = 1'b0;
          client_tdata[c*DW +: DW] = DW'($urandom);
          client_tlast[c] = 1'($urandom_range(1));
        end
      end
      if (m_locked) begin
        if (exp_valid && axis_tready) begin
          void'(mq[m_grant].pop_front());
          out_log.push_back('{cyc, int'(axis_tid), axis_tlast, axis_tdata[DW-1:0], axis_tdest});
          $display("beat cyc=%0d ch=%0d data=%h last=%0b", cyc, axis_tid, axis_tdata[DW-1:0], axis_tlast);
          m_beats++;
          if (h.last) begin
            m_pkts++;
            m_rr = (m_grant + 1) % NCH;
            m_locked = 0;
          end
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          idx = (m_rr + k) % NCH;
          if (!m_locked && mq[idx].size() != 0) begin
            m_grant = idx;
            m_locked = 1;
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (client_valid[c] && rdy_now[c]) begin
          mq[c].push_back(src_q[c].pop_front());
          wr_cnt[c]++;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
      end
    end
  end

  task automatic push(input int c, input logic [DW-1:0] d, input logic l);
    src_q[c].push_back('{last: l, data: d});
  endtask

  task automatic clear_logs();
    out_log.delete();
    first_wr_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_log(input int n, input int maxc);
    int i = 0;
    while (out_log.size() < n && i < maxc) begin
      @(posedge clk);
      i++;
    end
    #2;
    if (out_log.size() < n) check("wait_timeout", 64'(out_log.size()), 64'(n));
  endtask

  logic [DW-1:0] exp_rand [NCH][$];
  int            exp_ch   [8];
  int            exp_dat  [8];
  int            base, total, c, len, pend;
  logic          prev_last;
  int            prev_ch;
  logic [DW-1:0] d;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Single channel, 3-beat packet: latency 2 from the first write
    clear_logs();
    push(0, 16'd10, 1'b0); push(0, 16'd20, 1'b0); push(0, 16'd30, 1'b1);
    wait_log(3, 50);
    for (int i = 0; i < 3; i++) begin
      check("t1_latency", 64'(out_log[i].cyc - first_wr_cyc), 64'(2 + i));
      check("t1_data", out_log[i].data, 64'(10 * (i + 1)));
      check("t1_last", out_log[i].last, (i == 2));
      check("t1_tid", 64'(out_log[i].ch), 0);
      check("t1_dest", out_log[i].dest, 12'h0A0);
    end
    check("t1_beats", beats_sent, 3);
    check("t1_pkts", pkts_sent, 1);

    // Round-robin: ch1 and ch3 each hold two 2-beat packets, rr_ptr=0
    do_reset();
    push(1, 16'h11, 0); push(1, 16'h12, 1); push(1, 16'h13, 0); push(1, 16'h14, 1);
    push(3, 16'h31, 0); push(3, 16'h32, 1); push(3, 16'h33, 0); push(3, 16'h34, 1);
    exp_ch  = '{1, 1, 3, 3, 1, 1, 3, 3};
    exp_dat = '{'h11, 'h12, 'h31, 'h32, 'h13, 'h14, 'h33, 'h34};
    wait_log(8, 100);
    for (int i = 0; i < 8; i++) begin
      check("t2_order_ch", 64'(out_log[i].ch), 64'(exp_ch[i]));
      check("t2_order_data", out_log[i].data, 64'(exp_dat[i]));
    end

    // Backpressure mid-packet for 5 cycles
    clear_logs();
    push(2, 16'hA1, 0); push(2, 16'hA2, 0); push(2, 16'hA3, 0); push(2, 16'hA4, 1);
    wait_log(1, 50);
    rdy_pct = 0;
    repeat (5) begin
      check("t3_hold_valid", axis_tvalid, 1);
      check("t3_hold_data", axis_tdata, 64'hA2);
      check("t3_hold_last", axis_tlast, 0);
      check("t3_hold_dest", axis_tdest, 12'h222);
      check("t3_hold_beats", beats_sent, 9);
      check("t3_hold_pkts", pkts_sent, 4);
      @(posedge clk); #2;
    end
    rdy_pct = 100;
    wait_log(4, 50);
    for (int i = 0; i < 4; i++) check("t3_data", out_log[i].data, 64'(16'hA1 + i));
    check("t3_count", 64'(out_log.size()), 4);

    // Full FIFO: 6 beats into a 4-deep FIFO with tready low
    clear_logs();
    rdy_pct = 0;
    base = wr_cnt[2];
    for (int i = 0; i < 6; i++) push(2, 16'(16'hB1 + i), (i == 5));
    for (int i = 0; i < 40 && (wr_cnt[2] - base) < 4; i++) @(posedge clk);
    #2;
    check("t4_writes", 64'(wr_cnt[2] - base), 4);
    check("t4_ready_low", client_ready[2], 0);
    check("t4_held", 64'(src_q[2].size()), 2);
    repeat (3) @(posedge clk);
    #2;
    check("t4_still_full", client_ready[2], 0);
    check("t4_no_extra_wr", 64'(wr_cnt[2] - base), 4);
    rdy_pct = 100;
    wait_log(6, 60);
    for (int i = 0; i < 6; i++) begin
      check("t4_data", out_log[i].data, 64'(16'hB1 + i));
      check("t4_last", out_log[i].last, (i == 5));
    end

    // Mid-packet starvation keeps the lock on ch0
    clear_logs();
    push(0, 16'hC1, 0);
    wait_log(1, 50);
    push(1, 16'hD1, 0); push(1, 16'hD2, 1);
    repeat (6) @(posedge clk);
    #2;
    check("t5_waiting", 64'(out_log.size()), 1);
    check("t5_bubble", axis_tvalid, 0);
    push(0, 16'hC2, 1);
    wait_log(4, 50);
    exp_ch[0:3]  = '{0, 0, 1, 1};
    exp_dat[0:3] = '{'hC1, 'hC2, 'hD1, 'hD2};
    for (int i = 0; i < 4; i++) begin
      check("t5_ch", 64'(out_log[i].ch), 64'(exp_ch[i]));
      check("t5_data", out_log[i].data, 64'(exp_dat[i]));
    end

    // Asynchronous reset mid-packet, between clock edges
    clear_logs();
    for (int i = 0; i < 4; i++) push(0, 16'(16'hE1 + i), (i == 3));
    wait_log(2, 50);
    @(posedge clk); #3;
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    #1;
    check("t6_rst_valid", axis_tvalid, 0);
    check("t6_rst_ready", client_ready, 4'hF);
    check("t6_rst_beats", beats_sent, 0);
    check("t6_rst_pkts", pkts_sent, 0);
    check("t6_rst_last", axis_tlast, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    clear_logs();
    push(0, 16'hF1, 0); push(0, 16'hF2, 0); push(0, 16'hF3, 1);
    wait_log(3, 50);
    for (int i = 0; i < 3; i++) begin
      check("t6_latency", 64'(out_log[i].cyc - first_wr_cyc), 64'(2 + i));
      check("t6_data", out_log[i].data, 64'(16'hF1 + i));
    end
    check("t6_beats", beats_sent, 3);
    check("t6_pkts", pkts_sent, 1);

    // Random traffic on all channels with random valid/ready
    clear_logs();
    vld_pct = 70; rdy_pct = 70; total = 0;
    for (int it = 0; it < 400; it++) begin
      @(posedge clk); #2;
      if ($urandom_range(3) == 0) begin
        c = $urandom_range(NCH - 1);
        len = $urandom_range(4, 1);
        for (int j = 0; j < len; j++) begin
          d = DW'($urandom);
          push(c, d, (j == len - 1));
          exp_rand[c].push_back(d);
        end
        total += len;
      end
    end
    vld_pct = 100; rdy_pct = 100;
    wait_log(total, 3000);
    check("rand_count", 64'(out_log.size()), 64'(total));
    prev_last = 1'b1; prev_ch = -1;
    foreach (out_log[i]) begin
      if (!prev_last) check("rand_no_interleave", 64'(out_log[i].ch), 64'(prev_ch));
      check("rand_order", out_log[i].data, exp_rand[out_log[i].ch].pop_front());
      prev_last = out_log[i].last;
      prev_ch = out_log[i].ch;
    end
    pend = 0;
    for (int k = 0; k < NCH; k++) pend += mq[k].size() + src_q[k].size();
    check("rand_drained", 64'(pend), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
